// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the datapath's instruction memory: stores bytes big-endian,
// gates execution with run_en and serves a zero-latency 4-byte fetch port.
module instr_mem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              run_en,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic [31:0]       fetch_instr
);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  // Two extra bits so load_len*4 never truncates before the DEPTH comparison.
  localparam logic [ADDR_W+1:0] DEPTH_B = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W+1:0] ONE_B   = (ADDR_W+2)'(1);

  logic [7:0]        mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W+1:0] remaining;
  logic [ADDR_W+1:0] len_bytes;
  logic              accept;
  logic [ADDR_W-1:0] pc1, pc2, pc3;

  assign len_bytes = {load_len, 2'b00};
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      remaining <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      run_en    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE, READY: begin
          // A rejected request leaves state, and any loaded program, untouched.
          if (load_start) begin
            if (len_bytes == '0) begin
              state  <= READY;
              done   <= 1'b1;
              run_en <= 1'b1;
            end else if (len_bytes > DEPTH_B) begin
              err <= 1'b1;
            end else begin
              state     <= LOAD;
              wr_ptr    <= '0;
              remaining <= len_bytes;
              busy      <= 1'b1;
              in_ready  <= 1'b1;
              run_en    <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            wr_ptr    <= wr_ptr + ADDR_W'(1);
            remaining <= remaining - ONE_B;
            if (remaining == ONE_B) begin
              state    <= READY;
              busy     <= 1'b0;
              in_ready <= 1'b0;
              done     <= 1'b1;
              run_en   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory contents survive reset; only the control path is cleared.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= in_byte;
  end

  assign pc1 = fetch_pc + ADDR_W'(1);
  assign pc2 = fetch_pc + ADDR_W'(2);
  assign pc3 = fetch_pc + ADDR_W'(3);

  always_comb begin
    fetch_instr = 32'h0000_0000;
    if (run_en) fetch_instr = {mem[fetch_pc], mem[pc1], mem[pc2], mem[pc3]};
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: load, backpressure, overflow, wrap, reset and reload.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [7:0]  load_len;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready, busy, done, err, run_en;
  logic [7:0]  fetch_pc;
  logic [31:0] fetch_instr;

  logic [7:0]  prog [256];
  int          tests = 0;
  int          fails = 0;

  instr_mem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_len(load_len),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready), .busy(busy),
    .done(done), .err(err), .run_en(run_en), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch_check(input string tag, input logic [7:0] pc, input logic [31:0] exp);
    fetch_pc = pc;
    #1;
    check(tag, fetch_instr, exp);
  endtask

  // Requests a load of nwords, streams prog[0..], idles `gap` cycles between bytes;
  // poke pulses load_start with load_len=0 mid-load, which must be ignored.
  task automatic do_load(input string tag, input int nwords, input int gap, input bit poke);
    int hs = 0;
    int done_cnt = 0;
    bit busy_bad = 0;
    load_start = 1'b1;
    load_len   = 8'(nwords);
    tick();
    load_start = 1'b0;
    for (int i = 0; i < nwords * 4; i++) begin
      in_valid = 1'b1;
      in_byte  = prog[i];
      if (in_ready === 1'b1) hs++;
      if (busy !== 1'b1) busy_bad = 1;
      tick();
      if (done === 1'b1) done_cnt++;
      in_valid = 1'b0;
      if (i != nwords * 4 - 1) begin
        for (int g = 0; g < gap; g++) begin
          if (busy !== 1'b1) busy_bad = 1;
          if (poke && i == 0 && g == 0) begin
            load_start = 1'b1;
            load_len   = 8'd0;
          end
          tick();
          load_start = 1'b0;
          if (done === 1'b1) done_cnt++;
        end
      end
    end
    check({tag, " handshakes"}, 32'(hs), 32'(nwords * 4));
    check({tag, " done after last byte"}, {31'b0, done}, 32'd1);
    check({tag, " done count"}, 32'(done_cnt), 32'd1);
    check({tag, " busy throughout"}, {31'b0, busy_bad}, 32'd0);
    check({tag, " run_en"}, {31'b0, run_en}, 32'd1);
    check({tag, " in_ready dropped"}, {31'b0, in_ready}, 32'd0);
    tick();
    check({tag, " done one cycle"}, {31'b0, done}, 32'd0);
  endtask

  task automatic bad_len(input string tag, input logic [7:0] len, input logic exp_run);
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
    check({tag, " err"}, {31'b0, err}, 32'd1);
    check({tag, " no done"}, {31'b0, done}, 32'd0);
    check({tag, " in_ready"}, {31'b0, in_ready}, 32'd0);
    check({tag, " run_en"}, {31'b0, run_en}, {31'b0, exp_run});
    tick();
    check({tag, " err one cycle"}, {31'b0, err}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; load_len = '0;
    in_valid = 1'b0; in_byte = '0; fetch_pc = '0;
    #12;
    check("reset in_ready", {31'b0, in_ready}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset err", {31'b0, err}, 32'd0);
    check("reset run_en", {31'b0, run_en}, 32'd0);
    check("reset fetch", fetch_instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Overflow from IDLE, including lengths that would alias if truncated
    bad_len("ovf65", 8'd65, 1'b0);
    bad_len("ovf128", 8'd128, 1'b0);
    bad_len("ovf192", 8'd192, 1'b0);
    check("ovf busy", {31'b0, busy}, 32'd0);

    // Load without stalls
    prog[0] = 8'h00; prog[1] = 8'h22; prog[2] = 8'h18; prog[3] = 8'h00;
    prog[4] = 8'h04; prog[5] = 8'h85; prog[6] = 8'h30; prog[7] = 8'h00;
    do_load("nostall", 2, 0, 1'b0);
    fetch_check("nostall pc0", 8'd0, 32'h0022_1800);
    fetch_check("nostall pc4", 8'd4, 32'h0485_3000);

    // Backpressure with an ignored load_start mid-load
    do_load("bp", 2, 3, 1'b1);
    fetch_check("bp pc0", 8'd0, 32'h0022_1800);
    fetch_check("bp pc4", 8'd4, 32'h0485_3000);
    fetch_check("bp pc2", 8'd2, 32'h1800_0485);

    // Full memory with fetch wrap-around
    for (int i = 0; i < 256; i++) prog[i] = 8'(i);
    prog[0] = 8'h11; prog[1] = 8'h22;
    prog[252] = 8'hAA; prog[253] = 8'hBB; prog[254] = 8'hCC; prog[255] = 8'hDD;
    do_load("wrap", 64, 0, 1'b0);
    fetch_check("wrap pc254", 8'd254, 32'hCCDD_1122);
    fetch_check("wrap pc252", 8'd252, 32'hAABB_CCDD);
    fetch_check("wrap pc255", 8'd255, 32'hDD11_2202);

    // Reset after 5 of 8 bytes
    load_start = 1'b1;
    load_len   = 8'd2;
    tick();
    load_start = 1'b0;
    check("rst restart run_en low", {31'b0, run_en}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'h50 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    check("rst mid busy", {31'b0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async in_ready", {31'b0, in_ready}, 32'd0);
    check("rst async busy", {31'b0, busy}, 32'd0);
    check("rst async done", {31'b0, done}, 32'd0);
    check("rst async run_en", {31'b0, run_en}, 32'd0);
    check("rst async fetch", fetch_instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    prog[0] = 8'hDE; prog[1] = 8'hAD; prog[2] = 8'hBE; prog[3] = 8'hEF;
    do_load("postrst", 1, 0, 1'b0);
    fetch_check("postrst pc0", 8'd0, 32'hDEAD_BEEF);
    fetch_check("postrst partial pc4", 8'd4, 32'h5405_0607);

    // Reload from READY
    load_start = 1'b1;
    load_len   = 8'd1;
    tick();
    load_start = 1'b0;
    check("reload run_en fall", {31'b0, run_en}, 32'd0);
    check("reload busy", {31'b0, busy}, 32'd1);
    check("reload fetch gated", fetch_instr, 32'h0);
    prog[0] = 8'h12; prog[1] = 8'h34; prog[2] = 8'h56; prog[3] = 8'h78;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_byte  = prog[i];
      tick();
    end
    in_valid = 1'b0;
    check("reload done", {31'b0, done}, 32'd1);
    check("reload run_en", {31'b0, run_en}, 32'd1);
    fetch_check("reload pc0", 8'd0, 32'h1234_5678);

    // Rejected restarts from READY keep the program
    bad_len("ready ovf65", 8'd65, 1'b1);
    bad_len("ready ovf192", 8'd192, 1'b1);
    fetch_check("ready ovf keeps prog", 8'd0, 32'h1234_5678);

    // Zero-length load from READY
    load_start = 1'b1;
    load_len   = 8'd0;
    tick();
    load_start = 1'b0;
    check("zero done", {31'b0, done}, 32'd1);
    check("zero no err", {31'b0, err}, 32'd0);
    check("zero run_en", {31'b0, run_en}, 32'd1);
    check("zero not busy", {31'b0, busy}, 32'd0);
    tick();
    check("zero done one cycle", {31'b0, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
